memory_arbiter: RTL

Arbitrates the single-port 256x8 program/data memory (`register_file`) between two requesters: the user loader port and the controller's instruction-fetch port. It replaces the hard `op` address mux in front of the memory with a req/ack handshake. Both requesters can then coexist, and a loader cannot corrupt an in-flight fetch. It sits between the controller/loader and the memory, and drives the memory's address, data and write strobe.

---
 rtl/memory_arbiter_pkg.sv | 19 +
 rtl/memory_arbiter_rr_arbiter2.sv | 21 ++
 rtl/memory_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared types and defaults for the program/data memory arbiter.
package memory_arbiter_pkg;

    localparam int unsigned DEF_AW  = 8;
    localparam int unsigned DEF_DW  = 8;
    localparam int unsigned NUM_REQ = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic {
        REQ_LD = 1'b0,
        REQ_FE = 1'b1
    } req_id_t;

endpackage

// File: rtl/memory_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: on a tie the requester not granted last wins.
module rr_arbiter2
    import memory_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  req_id_t            last_grant,
    output logic               gnt_valid_c,
    output req_id_t            gnt_id_c
);

    always_comb begin
        gnt_valid_c = |req;
        gnt_id_c    = REQ_LD;
        if (req[0] && req[1]) begin
            gnt_id_c = (last_grant == REQ_FE) ? REQ_LD : REQ_FE;
        end else if (req[1]) begin
            gnt_id_c = REQ_FE;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Req/ack arbiter between the loader and instruction-fetch ports of the
// single-port program/data memory; one access per three-cycle transaction.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned AW = DEF_AW,
    parameter int unsigned DW = DEF_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          op,
    input  logic          ld_req,
    input  logic          ld_wr,
    input  logic [AW-1:0] ld_address,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ack,
    output logic [DW-1:0] ld_rdata,
    input  logic          fe_req,
    input  logic [AW-1:0] fe_address,
    output logic          fe_ack,
    output logic [DW-1:0] fe_rdata,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_in_data,
    output logic          mem_wr,
    input  logic [DW-1:0] mem_out_data,
    output logic          busy
);

    state_t  state;
    state_t  state_nxt;
    req_id_t last_grant;
    req_id_t last_grant_nxt;
    req_id_t winner;
    req_id_t winner_nxt;

    logic [NUM_REQ-1:0] eligible_c;
    logic               gnt_valid_c;
    req_id_t            gnt_id_c;

    logic          ld_ack_nxt;
    logic          fe_ack_nxt;
    logic          mem_wr_nxt;
    logic          busy_nxt;
    logic [AW-1:0] mem_address_nxt;
    logic [DW-1:0] mem_in_data_nxt;
    logic [DW-1:0] ld_rdata_nxt;
    logic [DW-1:0] fe_rdata_nxt;

    // Fetches are only eligible in run mode; a load-mode fetch stays pending.
    assign eligible_c = {fe_req & op, ld_req};

    rr_arbiter2 u_rr_arbiter2 (
        .req         (eligible_c),
        .last_grant  (last_grant),
        .gnt_valid_c (gnt_valid_c),
        .gnt_id_c    (gnt_id_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (gnt_valid_c) state_nxt = ST_ACCESS;
            ST_ACCESS: state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; requests are only looked at in IDLE.
    always_comb begin
        last_grant_nxt  = last_grant;
        winner_nxt      = winner;
        mem_address_nxt = mem_address;
        mem_in_data_nxt = mem_in_data;
        ld_rdata_nxt    = ld_rdata;
        fe_rdata_nxt    = fe_rdata;
        mem_wr_nxt      = 1'b0;
        ld_ack_nxt      = 1'b0;
        fe_ack_nxt      = 1'b0;
        busy_nxt        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (gnt_valid_c) begin
                    winner_nxt     = gnt_id_c;
                    last_grant_nxt = gnt_id_c;
                    busy_nxt       = 1'b1;
                    if (gnt_id_c == REQ_LD) begin
                        mem_address_nxt = ld_address;
                        mem_in_data_nxt = ld_data;
                        mem_wr_nxt      = ld_wr;
                    end else begin
                        mem_address_nxt = fe_address;
                    end
                end
            end
            ST_ACCESS: begin
                busy_nxt = 1'b1;
                if (winner == REQ_LD) begin
                    ld_ack_nxt = 1'b1;
                    if (!mem_wr) begin
                        ld_rdata_nxt = mem_out_data;
                    end
                end else begin
                    fe_ack_nxt   = 1'b1;
                    fe_rdata_nxt = mem_out_data;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant  <= REQ_FE;
            winner      <= REQ_LD;
            mem_address <= '0;
            mem_in_data <= '0;
            mem_wr      <= 1'b0;
            ld_ack      <= 1'b0;
            fe_ack      <= 1'b0;
            ld_rdata    <= '0;
            fe_rdata    <= '0;
            busy        <= 1'b0;
        end else begin
            last_grant  <= last_grant_nxt;
            winner      <= winner_nxt;
            mem_address <= mem_address_nxt;
            mem_in_data <= mem_in_data_nxt;
            mem_wr      <= mem_wr_nxt;
            ld_ack      <= ld_ack_nxt;
            fe_ack      <= fe_ack_nxt;
            ld_rdata    <= ld_rdata_nxt;
            fe_rdata    <= fe_rdata_nxt;
            busy        <= busy_nxt;
        end
    end

endmodule
